// File: rtl/imem_port_arbiter.sv
// Instruction memory port arbiter: loader writes vs core fetch reads
// on one synchronous single-port memory, with a starvation guard.
module imem_port_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_rsp_valid,
  output logic [DATA_W-1:0] fetch_rsp_data,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]     starve_cnt;
  logic              starved;
  logic              rsp_q;
  logic              grant_fetch;
  logic              grant_load;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign starved = (starve_cnt == LIMIT);

  always_comb begin
    grant_fetch = 1'b0;
    grant_load  = 1'b0;
    if (!rst) begin
      if (load_lock) begin
        grant_load = load_valid;
      end else if (fetch_valid && (!load_valid || starved)) begin
        grant_fetch = 1'b1;
      end else begin
        grant_load = load_valid;
      end
    end
  end

  assign fetch_ready = grant_fetch;
  assign load_ready  = grant_load;
  assign mem_en      = grant_fetch | grant_load;
  assign mem_we      = grant_load;

  // Idle cycles replay the last address/data so the memory bus stays quiet.
  always_comb begin
    mem_addr = addr_q;
    if (grant_load) begin
      mem_addr = load_addr;
    end else if (grant_fetch) begin
      mem_addr = fetch_addr;
    end
  end

  assign mem_wdata = grant_load ? load_data : wdata_q;

  // A response pending across reset entry is suppressed immediately.
  assign fetch_rsp_valid = rsp_q & ~rst;
  assign fetch_rsp_data  = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      rsp_q <= grant_fetch;
      // Lock freezes the count so fetch resumes its priority on release.
      if (!load_lock) begin
        if (grant_fetch || !fetch_valid) begin
          starve_cnt <= '0;
        end else if (!starved) begin
          starve_cnt <= starve_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_en) begin
      addr_q <= mem_addr;
    end
    if (grant_load) begin
      wdata_q <= load_data;
    end
  end

endmodule
